// File: rtl/cu_sequencer.sv
// ============================================================================
// Module   : cu_sequencer
// Brief    : Control-unit instruction sequencer: fetch/decode/execute/writeback
//            handshakes, PC ownership and halt handling. Optional watchdog on
//            wait states is enabled by defining SEQ_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cu_sequencer #(
    parameter logic [31:0] PC_RESET       = 32'd0,
    parameter logic [31:0] PC_LIMIT       = 32'd512,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        run,
    output logic        fetch_start,
    output logic [31:0] fetch_pc,
    input  logic        fetch_done,
    output logic        decode_start,
    input  logic        IDU_ready,
    input  logic        invalid_instruction,
    input  logic        is_system,
    input  logic [1:0]  instr_class,
    input  logic [31:0] pc_increment,
    output logic        alu_start,
    input  logic        ALU_ready,
    input  logic        ALU_err,
    input  logic [31:0] ALU_result,
    input  logic        branch_flag,
    output logic        wb_en,
    output logic        retired,
    output logic [31:0] instr_count,
    output logic [31:0] pc,
    output logic        halted,
    output logic [2:0]  halt_cause
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] c_CAUSE_INVALID = 3'd1;
    localparam logic [2:0] c_CAUSE_ALU     = 3'd2;
    localparam logic [2:0] c_CAUSE_BADPC   = 3'd3;
    localparam logic [2:0] c_CAUSE_SYSTEM  = 3'd4;
    localparam logic [2:0] c_CAUSE_TIMEOUT = 3'd5;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_count;
    logic [31:0] r_incr;
    logic [1:0]  r_class;
    logic        r_fetch_start;
    logic        r_decode_start;
    logic        r_alu_start;
    logic        r_wb_en;
    logic        r_retired;
    logic        r_halted;
    logic [2:0]  r_cause;

    logic [31:0] w_pc_seq;
    logic [31:0] w_pc_rel;
    logic [31:0] w_pc_jalr;
    logic [31:0] w_pc_next;
    logic        w_pc_bad;
    logic        w_wd_expired;

    assign w_pc_seq  = r_pc + 32'd4;
    assign w_pc_rel  = r_pc + r_incr;
    assign w_pc_jalr = ALU_result & 32'hFFFF_FFFE;
    assign w_pc_bad  = (r_pc >= PC_LIMIT) || (r_pc[1:0] != 2'b00);

    // branch_flag / ALU_result are consumed live on the ALU_ready cycle,
    // so the PC register itself acts as their latch.
    always_comb begin
        w_pc_next = w_pc_seq;
        case (r_class)
            2'b00:   w_pc_next = w_pc_seq;
            2'b01:   w_pc_next = branch_flag ? w_pc_rel : w_pc_seq;
            2'b10:   w_pc_next = w_pc_rel;
            default: w_pc_next = w_pc_jalr;
        endcase
    end

`ifdef SEQ_WATCHDOG_EN
    logic [31:0] r_wdog;
    logic        w_waiting;

    assign w_waiting = ((r_state == S_FETCH)  && !fetch_done) ||
                       ((r_state == S_DECODE) && !IDU_ready)  ||
                       ((r_state == S_EXEC)   && !ALU_ready && !ALU_err);
    assign w_wd_expired = w_waiting && (r_wdog == 32'(TIMEOUT_CYCLES - 1));

    // Any cycle that is not a stalled wait (including state entry) clears it.
    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            r_wdog <= '0;
        end else if (w_waiting) begin
            r_wdog <= r_wdog + 32'd1;
        end else begin
            r_wdog <= '0;
        end
    end
`else
    assign w_wd_expired = 1'b0;
`endif

    always_ff @(posedge soc_clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_pc           <= PC_RESET;
            r_count        <= '0;
            r_incr         <= '0;
            r_class        <= 2'b00;
            r_fetch_start  <= 1'b0;
            r_decode_start <= 1'b0;
            r_alu_start    <= 1'b0;
            r_wb_en        <= 1'b0;
            r_retired      <= 1'b0;
            r_halted       <= 1'b0;
            r_cause        <= 3'd0;
        end else begin
            r_fetch_start  <= 1'b0;
            r_decode_start <= 1'b0;
            r_alu_start    <= 1'b0;
            r_wb_en        <= 1'b0;
            r_retired      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state       <= S_FETCH;
                        r_fetch_start <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (fetch_done) begin
                        r_state        <= S_DECODE;
                        r_decode_start <= 1'b1;
                    end else if (w_wd_expired) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_cause  <= c_CAUSE_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    if (IDU_ready) begin
                        if (invalid_instruction) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                            r_cause  <= c_CAUSE_INVALID;
                        end else if (is_system) begin
                            r_retired <= 1'b1;
                            r_count   <= r_count + 32'd1;
                            r_state   <= S_HALT;
                            r_halted  <= 1'b1;
                            r_cause   <= c_CAUSE_SYSTEM;
                        end else begin
                            r_state     <= S_EXEC;
                            r_alu_start <= 1'b1;
                            r_class     <= instr_class;
                            r_incr      <= pc_increment;
                        end
                    end else if (w_wd_expired) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_cause  <= c_CAUSE_TIMEOUT;
                    end
                end
                S_EXEC: begin
                    if (ALU_err) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_cause  <= c_CAUSE_ALU;
                    end else if (ALU_ready) begin
                        r_state   <= S_WB;
                        r_wb_en   <= 1'b1;
                        r_retired <= 1'b1;
                        r_count   <= r_count + 32'd1;
                        r_pc      <= w_pc_next;
                    end else if (w_wd_expired) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_cause  <= c_CAUSE_TIMEOUT;
                    end
                end
                S_WB: begin
                    // The offending PC is left in r_pc so it stays observable.
                    if (w_pc_bad) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_cause  <= c_CAUSE_BADPC;
                    end else if (run) begin
                        r_state       <= S_FETCH;
                        r_fetch_start <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fetch_start  = r_fetch_start;
    assign fetch_pc     = r_pc;
    assign decode_start = r_decode_start;
    assign alu_start    = r_alu_start;
    assign wb_en        = r_wb_en;
    assign retired      = r_retired;
    assign instr_count  = r_count;
    assign pc           = r_pc;
    assign halted       = r_halted;
    assign halt_cause   = r_cause;

endmodule

`default_nettype wire

// File: tb/tb_cu_sequencer.sv
// ============================================================================
// Module   : tb_cu_sequencer
// Brief    : Directed self-checking bench for cu_sequencer (hand-computed
//            expectations; watchdog section follows SEQ_WATCHDOG_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cu_sequencer;

    logic        soc_clk = 1'b0;
    logic        reset;
    logic        run;
    logic        fetch_start;
    logic [31:0] fetch_pc;
    logic        fetch_done;
    logic        decode_start;
    logic        IDU_ready;
    logic        invalid_instruction;
    logic        is_system;
    logic [1:0]  instr_class;
    logic [31:0] pc_increment;
    logic        alu_start;
    logic        ALU_ready;
    logic        ALU_err;
    logic [31:0] ALU_result;
    logic        branch_flag;
    logic        wb_en;
    logic        retired;
    logic [31:0] instr_count;
    logic [31:0] pc;
    logic        halted;
    logic [2:0]  halt_cause;

    int n_vec = 0;
    int n_err = 0;

    cu_sequencer #(
        .PC_RESET      (32'd0),
        .PC_LIMIT      (32'd512),
        .TIMEOUT_CYCLES(10)
    ) u_dut (
        .soc_clk            (soc_clk),
        .reset              (reset),
        .run                (run),
        .fetch_start        (fetch_start),
        .fetch_pc           (fetch_pc),
        .fetch_done         (fetch_done),
        .decode_start       (decode_start),
        .IDU_ready          (IDU_ready),
        .invalid_instruction(invalid_instruction),
        .is_system          (is_system),
        .instr_class        (instr_class),
        .pc_increment       (pc_increment),
        .alu_start          (alu_start),
        .ALU_ready          (ALU_ready),
        .ALU_err            (ALU_err),
        .ALU_result         (ALU_result),
        .branch_flag        (branch_flag),
        .wb_en              (wb_en),
        .retired            (retired),
        .instr_count        (instr_count),
        .pc                 (pc),
        .halted             (halted),
        .halt_cause         (halt_cause)
    );

    always #5 soc_clk = ~soc_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge soc_clk);
        #1;
    endtask

    // Reset asserted just after an edge, checked asynchronously, released next cycle.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
        chk({tag, "_cause"}, {29'd0, halt_cause}, 32'd0);
        chk({tag, "_count"}, instr_count, 32'd0);
        chk({tag, "_pulses"}, {27'd0, fetch_start, decode_start, alu_start, wb_en, retired}, 32'd0);
        tick();
        reset = 1'b1;
    endtask

    // One instruction with every unit answering at once; starts from IDLE/WB with run=1.
    task automatic run_instr(input string tag, input logic [1:0] cls, input logic [31:0] inc,
                             input logic bf, input logic [31:0] alu_res,
                             input logic [31:0] exp_fpc, input logic [31:0] exp_pc,
                             input logic [31:0] exp_cnt);
        instr_class  = cls;
        pc_increment = inc;
        branch_flag  = bf;
        ALU_result   = alu_res;
        tick();
        chk({tag, "_fstart"}, {31'd0, fetch_start}, 32'd1);
        chk({tag, "_fpc"}, fetch_pc, exp_fpc);
        tick();
        chk({tag, "_dstart"}, {30'd0, fetch_start, decode_start}, 32'd1);
        tick();
        chk({tag, "_astart"}, {30'd0, decode_start, alu_start}, 32'd1);
        tick();
        chk({tag, "_wb"}, {29'd0, alu_start, wb_en, retired}, 32'd3);
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_count"}, instr_count, exp_cnt);
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; fetch_done = 1'b0; IDU_ready = 1'b0;
        invalid_instruction = 1'b0; is_system = 1'b0; instr_class = 2'b00;
        pc_increment = 32'd0; ALU_ready = 1'b0; ALU_err = 1'b0;
        ALU_result = 32'd0; branch_flag = 1'b0;

        tick();
        tick();
        chk("rst_pc", pc, 32'd0);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_halt", {28'd0, halted, halt_cause}, 32'd0);
        reset = 1'b1;

        // Sequential and control-flow sweep, all units answering same cycle.
        fetch_done = 1'b1; IDU_ready = 1'b1; ALU_ready = 1'b1; run = 1'b1;
        run_instr("seq1", 2'b00, 32'd0, 1'b0, 32'd0, 32'd0, 32'd4, 32'd1);
        run_instr("seq2", 2'b00, 32'd0, 1'b0, 32'd0, 32'd4, 32'd8, 32'd2);
        run_instr("seq3", 2'b00, 32'd0, 1'b0, 32'd0, 32'd8, 32'd12, 32'd3);
        run_instr("br_back4", 2'b01, 32'hFFFF_FFFC, 1'b1, 32'd0, 32'd12, 32'd8, 32'd4);
        run_instr("br_taken", 2'b01, 32'hFFFF_FFF8, 1'b1, 32'd0, 32'd8, 32'd0, 32'd5);
        run_instr("seq4", 2'b00, 32'd0, 1'b0, 32'd0, 32'd0, 32'd4, 32'd6);
        run_instr("seq5", 2'b00, 32'd0, 1'b0, 32'd0, 32'd4, 32'd8, 32'd7);
        run_instr("br_ntaken", 2'b01, 32'hFFFF_FFF8, 1'b0, 32'd0, 32'd8, 32'd12, 32'd8);
        run_instr("jalr", 2'b11, 32'h0000_0100, 1'b1, 32'h0000_0021, 32'd12, 32'h20, 32'd9);
        run_instr("jal_back", 2'b10, 32'hFFFF_FFE0, 1'b0, 32'h0000_0055, 32'h20, 32'd0, 32'd10);
        run_instr("jal_far", 2'b10, 32'h0000_0200, 1'b0, 32'd0, 32'd0, 32'h200, 32'd11);
        tick();
        chk("badpc_halt", {28'd0, halted, halt_cause}, {28'd0, 1'b1, 3'd3});
        chk("badpc_pc", pc, 32'h200);
        chk("badpc_nofetch", {31'd0, fetch_start}, 32'd0);
        tick();
        tick();
        chk("badpc_sticky", {28'd0, halted, halt_cause}, {28'd0, 1'b1, 3'd3});
        chk("badpc_count", instr_count, 32'd11);

        // Invalid instruction beats is_system; ALU_err is ignored outside EXEC.
        do_reset("rst_a");
        invalid_instruction = 1'b1; is_system = 1'b1; ALU_err = 1'b1;
        tick();
        tick();
        chk("inv_decode", {31'd0, decode_start}, 32'd1);
        tick();
        chk("inv_halt", {28'd0, halted, halt_cause}, {28'd0, 1'b1, 3'd1});
        chk("inv_noexec", {30'd0, alu_start, retired}, 32'd0);
        tick();
        chk("inv_hold", {29'd0, alu_start, retired, wb_en}, 32'd0);
        chk("inv_count", instr_count, 32'd0);

        // ALU_err together with ALU_ready.
        do_reset("rst_b");
        invalid_instruction = 1'b0; is_system = 1'b0; ALU_err = 1'b1; ALU_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("aluerr_start", {31'd0, alu_start}, 32'd1);
        chk("aluerr_nohalt", {31'd0, halted}, 32'd0);
        tick();
        chk("aluerr_halt", {28'd0, halted, halt_cause}, {28'd0, 1'b1, 3'd2});
        chk("aluerr_nowb", {30'd0, wb_en, retired}, 32'd0);
        chk("aluerr_pc", pc, 32'd0);

        // System instruction retires and halts.
        do_reset("rst_c");
        ALU_err = 1'b0; is_system = 1'b1;
        tick();
        tick();
        tick();
        chk("sys_halt", {28'd0, halted, halt_cause}, {28'd0, 1'b1, 3'd4});
        chk("sys_retired", {30'd0, retired, alu_start}, 32'd2);
        chk("sys_count", instr_count, 32'd1);
        tick();
        chk("sys_pulse_once", {31'd0, retired}, 32'd0);

        // Reset in the middle of a stalled EXEC.
        do_reset("rst_d");
        is_system = 1'b0; ALU_ready = 1'b0; instr_class = 2'b00;
        tick();
        tick();
        tick();
        chk("mid_astart", {31'd0, alu_start}, 32'd1);
        tick();
        chk("mid_wait", {29'd0, alu_start, wb_en, retired}, 32'd0);
        ALU_ready = 1'b1; run = 1'b0;
        do_reset("rst_mid");
        chk("mid_noretire", {30'd0, retired, wb_en}, 32'd0);
        tick();
        chk("mid_idle", {31'd0, fetch_start}, 32'd0);
        run = 1'b1;
        tick();
        chk("restart_fetch", {31'd0, fetch_start}, 32'd1);
        chk("restart_fpc", fetch_pc, 32'd0);
        run = 1'b0;
        tick();
        tick();
        tick();
        chk("runlow_wb", {30'd0, wb_en, retired}, 32'd3);
        chk("runlow_pc", pc, 32'd4);
        tick();
        tick();
        chk("runlow_idle", {28'd0, fetch_start, decode_start, alu_start, halted}, 32'd0);
        chk("runlow_count", instr_count, 32'd1);

        // Stalled FETCH: done accepted late; watchdog only if compiled in.
        do_reset("rst_e");
        fetch_done = 1'b0; run = 1'b1;
        tick();
        chk("wd_enter", {31'd0, fetch_start}, 32'd1);
        for (int i = 0; i < 9; i++) tick();
        chk("wd_pre", {31'd0, halted}, 32'd0);
        tick();
`ifdef SEQ_WATCHDOG_EN
        chk("wd_halt", {28'd0, halted, halt_cause}, {28'd0, 1'b1, 3'd5});
`else
        chk("wd_none", {28'd0, halted, halt_cause}, 32'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("wd_none_late", {31'd0, halted}, 32'd0);
        fetch_done = 1'b1;
        tick();
        chk("late_done", {31'd0, decode_start}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cu_sequencer.md
# cu_sequencer

Instruction sequencer for the core's control unit. Steps each instruction through fetch (mem_interface), decode (IDU_top), execute (ALU) and writeback using explicit start/done handshakes. Owns the program counter, resolves branch/JAL/JALR targets, and halts the core on fatal or system events. Sits between the CU register file and the three datapath units and replaces ad-hoc phase counting.

## Interface
- PC_RESET, 0: PC value after reset.
- PC_LIMIT, 512: first illegal PC (4*128 bytes of instruction memory).
- TIMEOUT_CYCLES, 255: watchdog limit per wait state (only used with the watchdog macro).

- soc_clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level enable; sequencing proceeds while high.
- fetch_start  out  1  one-cycle fetch request pulse.
- fetch_pc  out  32  address to fetch; equals pc.
- fetch_done  in  1  instruction word is in the IR.
- decode_start  out  1  one-cycle decode request pulse.
- IDU_ready  in  1  decode outputs valid.
- invalid_instruction  in  1  IDU decode error.
- is_system  in  1  decoded ECALL/EBREAK.
- instr_class  in  2  00 sequential, 01 branch, 10 JAL, 11 JALR.
- pc_increment  in  32  signed PC offset from the IDU.
- alu_start  out  1  one-cycle execute request pulse.
- ALU_ready  in  1  ALU result valid.
- ALU_err  in  1  ALU fault.
- ALU_result  in  32  JALR target source.
- branch_flag  in  1  branch condition result.
- wb_en  out  1  one-cycle register writeback strobe.
- retired  out  1  one-cycle pulse per completed instruction.
- instr_count  out  32  retired instruction count.
- pc  out  32  current PC.
- halted  out  1  sticky halt.
- halt_cause  out  3  0 none, 1 invalid instruction, 2 ALU error, 3 bad PC, 4 system, 5 timeout.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: go to FETCH when run=1.
- FETCH: fetch_start is high on the first FETCH cycle only. fetch_done moves the FSM to DECODE.
- DECODE: decode_start is high on the first DECODE cycle only. Once IDU_ready=1:
  - invalid_instruction → HALT, cause 1.
  - else is_system → pulse retired, increment instr_count, HALT, cause 4.
  - else → EXEC.
  - invalid_instruction wins over is_system in the same cycle.
- EXEC: alu_start is high on the first EXEC cycle only.
  - ALU_err → HALT, cause 2. ALU_err wins over ALU_ready in the same cycle.
  - ALU_ready → WB.
- WB (exactly 1 cycle): pulse wb_en and retired, increment instr_count, and update pc:
  - class 00: pc+4.
  - class 01: branch_flag ? pc+pc_increment : pc+4.
  - class 10: pc+pc_increment.
  - class 11: {ALU_result[31:1],1'b0}.
  - All additions are modulo 2^32. Branch/JAL/JALR operands are latched on the cycle the done signal is accepted.
- After the PC update:
  - New PC >= PC_LIMIT or new PC[1:0]≠0 → HALT, cause 3. The illegal value stays visible on pc.
  - Else run=1 → FETCH; run=0 → IDLE.
- run falling mid-instruction does not abort; the current instruction completes.
- HALT is absorbing. It is left only by reset. The first cause recorded is held.
- Done/error inputs outside their owning state are ignored.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, pc=PC_RESET, all pulses 0, instr_count=0, halted=0, halt_cause=0.
- Reset mid-operation abandons the instruction immediately. No wb_en or retired pulse is produced.
- Done inputs are accepted in any cycle of their state, including the cycle the start pulse is high.
- Minimum latency is 4 cycles per instruction (FETCH, DECODE, EXEC, WB). A start pulse for the next instruction follows WB by 1 cycle.
- All outputs are registered. halted rises in the cycle after the fault is sampled.
- instr_count wraps at 2^32.

## Configuration
- SEQ_WATCHDOG_EN defined: a counter clears on entry to FETCH, DECODE and EXEC and increments each waiting cycle. Reaching TIMEOUT_CYCLES without the state's done signal forces HALT with cause 5.
- SEQ_WATCHDOG_EN undefined: wait states never time out, cause 5 is never produced, and TIMEOUT_CYCLES is unused.

## Test plan
- Sequential path: PC_RESET=0, all units answer in the same cycle, class 00 ×3 → retired every 4 cycles, pc 0→4→8→12, instr_count=3.
- Branch taken: pc=8, class 01, branch_flag=1, pc_increment=-8 → pc=0. The same instruction with branch_flag=0 → pc=12.
- JALR: ALU_result=0x21 → pc=0x20. JAL with pc_increment=0x200 from pc=0 → HALT, cause 3, pc=0x200.
- Faults: invalid_instruction with IDU_ready → halted=1, cause 1, no alu_start. ALU_err and ALU_ready together → cause 2, no wb_en.
- Reset mid-EXEC: reset low for 1 cycle → pc=PC_RESET, state IDLE, no retired pulse. Operation restarts at 0 once run=1.
- Watchdog (macro on, TIMEOUT_CYCLES=10): fetch_done never asserted → HALT, cause 5, exactly 10 cycles after entering FETCH.
